// File: rtl/framebuf_pkg.sv
// framebuf_pkg: shared definitions for the frame buffer controller.
// Holds the register indices, the CTRL bit positions, the SIZE field offset and the
// FSM state encodings. It also provides a helper that packs the CTRL read word.
package framebuf_pkg;

  // Register indices on the 3-bit Wishbone address.
  localparam logic [2:0] RegCtrl   = 3'd0;
  localparam logic [2:0] RegBase0  = 3'd1;
  localparam logic [2:0] RegBase1  = 3'd2;
  localparam logic [2:0] RegStride = 3'd3;
  localparam logic [2:0] RegSize   = 3'd4;

  // CTRL bit positions.
  localparam int unsigned CtrlEnable = 0;  // RW
  localparam int unsigned CtrlSwap   = 1;  // write-1 requests a buffer swap, reads 0
  localparam int unsigned CtrlErr    = 2;  // sticky FIFO error, write-1 clears
  localparam int unsigned CtrlActive = 3;  // RO active buffer
  localparam int unsigned CtrlPend   = 4;  // RO swap pending
  localparam int unsigned CtrlIrq    = 5;  // interrupt pending, write-1 clears

  // SIZE register: linewords occupies the low bits, nlines starts here.
  localparam int unsigned SizeNlinesLsb = 16;

  // FSM state encodings.
  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StWaitVsync = 2'd1;
  localparam logic [1:0] StStart     = 2'd2;
  localparam logic [1:0] StRun       = 2'd3;

  // Packs the CTRL read word; the swap-request bit always reads back as 0.
  function automatic logic [31:0] ctrl_word(input logic enable, input logic err,
                                            input logic active, input logic pend,
                                            input logic irq);
    logic [31:0] w;
    w             = '0;
    w[CtrlEnable] = enable;
    w[CtrlErr]    = err;
    w[CtrlActive] = active;
    w[CtrlPend]   = pend;
    w[CtrlIrq]    = irq;
    return w;
  endfunction

endpackage

// File: rtl/framebuf_ctrl.sv
// framebuf_ctrl: Wishbone-programmable double-buffered frame buffer controller.
//
// Software programs two frame base addresses, a line stride and the frame size.
// On each frame start (i_vsync while running) the controller pulses o_newframe
// for one cycle and latches the frame geometry into the shadow outputs. A buffer
// swap requested through CTRL is applied only at a frame start, which raises the
// interrupt. FIFO overflows set a sticky error that also drives the interrupt.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_wb_*/o_wb_*             Wishbone slave: 3-bit register index, 32-bit data,
//                             no stall, ack one cycle after each request
//   i_vsync                   frame-start strobe (synchronous to i_clk)
//   i_fifo_err                image FIFO overflow indication
//   o_newframe                one-cycle frame restart pulse to the image FIFO
//   o_baseaddr, o_lineaddr    shadowed base address of the active buffer, line stride
//   o_linewords, o_nlines     shadowed words per line, lines per frame
//   o_int                     interrupt: interrupt pending OR sticky error
//
// ADDRESS_WIDTH must not exceed 32 and LW must fit in bits [31:16].
module framebuf_ctrl
  import framebuf_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 24,
  parameter int unsigned LGFLEN        = 11,
  parameter int unsigned LW            = 11
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [2:0]               i_wb_addr,
  input  logic [31:0]              i_wb_data,
  output logic                     o_wb_stall,
  output logic                     o_wb_ack,
  output logic [31:0]              o_wb_data,
  input  logic                     i_vsync,
  input  logic                     i_fifo_err,
  output logic                     o_newframe,
  output logic [ADDRESS_WIDTH-1:0] o_baseaddr,
  output logic [ADDRESS_WIDTH-1:0] o_lineaddr,
  output logic [LGFLEN:0]          o_linewords,
  output logic [LW-1:0]            o_nlines,
  output logic                     o_int
);

  localparam int unsigned AW = ADDRESS_WIDTH;

  // Bus handshake
  logic accept, wr_en;
  assign accept     = i_wb_stb && i_wb_cyc;
  assign wr_en      = accept && i_wb_we;
  assign o_wb_stall = 1'b0;

  // Only part of the write data is used by any single register.
  logic unused_wb_data;
  assign unused_wb_data = ^i_wb_data;

  // Programmable registers
  logic          enable_q, enable_d;
  logic [AW-1:0] base0_q, base0_d;
  logic [AW-1:0] base1_q, base1_d;
  logic [AW-1:0] stride_q, stride_d;
  logic [LGFLEN:0] linewords_q, linewords_d;
  logic [LW-1:0] nlines_q, nlines_d;

  // Status
  logic active_q, active_d;
  logic pend_q, pend_d;
  logic err_q, err_d;
  logic irq_q, irq_d;

  // FSM and registered outputs
  logic [1:0]      state_q, state_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            newframe_q, newframe_d;
  logic            int_q, int_d;
  logic [AW-1:0]   sh_base_q, sh_base_d;
  logic [AW-1:0]   sh_line_q, sh_line_d;
  logic [LGFLEN:0] sh_lw_q, sh_lw_d;
  logic [LW-1:0]   sh_nl_q, sh_nl_d;

  // Read mux: reflects register contents before any write in the same cycle.
  logic [31:0] rd_word;
  always_comb begin
    rd_word = '0;
    case (i_wb_addr)
      RegCtrl:   rd_word = ctrl_word(enable_q, err_q, active_q, pend_q, irq_q);
      RegBase0:  rd_word[AW-1:0] = base0_q;
      RegBase1:  rd_word[AW-1:0] = base1_q;
      RegStride: rd_word[AW-1:0] = stride_q;
      RegSize: begin
        rd_word[LGFLEN:0]              = linewords_q;
        rd_word[SizeNlinesLsb +: LW]   = nlines_q;
      end
      default:   rd_word = '0;
    endcase
  end

  // Next state. Order matters: bus writes first, then hardware events, so that a
  // set from an event beats a coincident software clear, and a swap request
  // written during START is consumed by that same START.
  always_comb begin
    enable_d    = enable_q;
    base0_d     = base0_q;
    base1_d     = base1_q;
    stride_d    = stride_q;
    linewords_d = linewords_q;
    nlines_d    = nlines_q;
    active_d    = active_q;
    pend_d      = pend_q;
    err_d       = err_q;
    irq_d       = irq_q;
    state_d     = state_q;
    sh_base_d   = sh_base_q;
    sh_line_d   = sh_line_q;
    sh_lw_d     = sh_lw_q;
    sh_nl_d     = sh_nl_q;

    if (wr_en) begin
      case (i_wb_addr)
        RegCtrl: begin
          enable_d = i_wb_data[CtrlEnable];
          if (i_wb_data[CtrlSwap]) pend_d = 1'b1;
          if (i_wb_data[CtrlErr])  err_d  = 1'b0;
          if (i_wb_data[CtrlIrq])  irq_d  = 1'b0;
        end
        RegBase0:  base0_d  = i_wb_data[AW-1:0];
        RegBase1:  base1_d  = i_wb_data[AW-1:0];
        RegStride: stride_d = i_wb_data[AW-1:0];
        RegSize: begin
          linewords_d = i_wb_data[LGFLEN:0];
          nlines_d    = i_wb_data[SizeNlinesLsb +: LW];
        end
        default: ;
      endcase
    end

    if (i_fifo_err) err_d = 1'b1;

    // Frame start: apply any pending swap and latch the geometry for this frame.
    if (state_q == StStart) begin
      if (pend_d) begin
        active_d = ~active_q;
        pend_d   = 1'b0;
        irq_d    = 1'b1;
      end
      sh_base_d = active_d ? base1_d : base0_d;
      sh_line_d = stride_d;
      sh_lw_d   = linewords_d;
      sh_nl_d   = nlines_d;
    end

    // Vsync is only observed in WAIT_VSYNC and RUN, so pulses never queue.
    if (!enable_q) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:      state_d = StWaitVsync;
        StWaitVsync: if (i_vsync) state_d = StStart;
        StStart:     state_d = StRun;
        StRun:       if (i_vsync) state_d = StStart;
        default:     state_d = StIdle;
      endcase
    end

    newframe_d = (state_d == StStart);
    ack_d      = accept;
    rdata_d    = accept ? rd_word : '0;
    int_d      = irq_d | err_d;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      enable_q    <= 1'b0;
      base0_q     <= '0;
      base1_q     <= '0;
      stride_q    <= '0;
      linewords_q <= '0;
      nlines_q    <= '0;
      active_q    <= 1'b0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
      state_q     <= StIdle;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      newframe_q  <= 1'b0;
      int_q       <= 1'b0;
      sh_base_q   <= '0;
      sh_line_q   <= '0;
      sh_lw_q     <= '0;
      sh_nl_q     <= '0;
    end else begin
      enable_q    <= enable_d;
      base0_q     <= base0_d;
      base1_q     <= base1_d;
      stride_q    <= stride_d;
      linewords_q <= linewords_d;
      nlines_q    <= nlines_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      state_q     <= state_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      newframe_q  <= newframe_d;
      int_q       <= int_d;
      sh_base_q   <= sh_base_d;
      sh_line_q   <= sh_line_d;
      sh_lw_q     <= sh_lw_d;
      sh_nl_q     <= sh_nl_d;
    end
  end

  assign o_wb_ack    = ack_q;
  assign o_wb_data   = rdata_q;
  assign o_newframe  = newframe_q;
  assign o_int       = int_q;
  assign o_baseaddr  = sh_base_q;
  assign o_lineaddr  = sh_line_q;
  assign o_linewords = sh_lw_q;
  assign o_nlines    = sh_nl_q;

endmodule
